player_input_conditioner: RTL and testbench

- Front end for the game controller's button/switch inputs; replaces the direct raw-button hookup.
- Synchronises and debounces 5 buttons and 8 switches, then produces clean levels and one-cycle edge pulses.
- Also serialises all input edges into a small event FIFO with a valid/ready handshake, so the game FSM and move checker never see bounce or metastability.

---
 rtl/player_input_conditioner_pkg.sv | 37 +++
 rtl/player_input_conditioner_debounce_cell.sv | 65 ++++++
 rtl/player_input_conditioner.sv | 179 +++++++++++++++++
 tb/tb_player_input_conditioner.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/player_input_conditioner_pkg.sv
// ---------------------------------------------------------------------------
// player_input_conditioner_pkg
// Shared constants for the player input conditioner: input counts, event
// field layout, control FSM encodings and an event-word builder.
// ---------------------------------------------------------------------------
package player_input_conditioner_pkg;

  localparam int NUM_BTNS = 5;
  localparam int NUM_SW   = 8;

  // Event word layout: [4]=release flag, [3]=type, [2:0]=index
  localparam int EVT_W        = 5;
  localparam int EVT_REL_BIT  = 4;
  localparam int EVT_TYPE_BIT = 3;
  localparam int EVT_IDX_MSB  = 2;

  localparam logic EVT_TYPE_BTN = 1'b0;
  localparam logic EVT_TYPE_SW  = 1'b1;

  typedef logic [EVT_W-1:0] evt_t;

  // Control FSM encodings
  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  function automatic evt_t make_evt(input logic rel, input logic typ,
                                    input logic [EVT_IDX_MSB:0] idx);
    evt_t e;
    e = '0;
    e[EVT_REL_BIT]       = rel;
    e[EVT_TYPE_BIT]      = typ;
    e[EVT_IDX_MSB:0]     = idx;
    return e;
  endfunction

endpackage

// File: rtl/player_input_conditioner_debounce_cell.sv
// ---------------------------------------------------------------------------
// debounce_cell
// One input's synchroniser, debounce counter, stable level and edge flag.
// Ports:
//   clk        system clock
//   rst        asynchronous reset, active-low
//   raw        asynchronous raw input
//   load       capture the synchronised value as the stable level (no edge)
//   run        normal debounce operation
//   level      debounced level
//   edge_pulse one-cycle pulse in the cycle the level changes
// ---------------------------------------------------------------------------
module debounce_cell
  import player_input_conditioner_pkg::*;
#(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic load,
  input  logic run,
  output logic level,
  output logic edge_pulse
);

  localparam int                CNT_W    = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;

  // Stage p0 -> p1: two-flop synchroniser, deliberately left out of reset
  always_ff @(posedge clk) begin
    sync_p0 <= raw;
    sync_p1 <= sync_p0;
  end

  // Debounce stage: a new level must persist for DB_CYCLES counts
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level      <= 1'b0;
      cnt        <= '0;
      edge_pulse <= 1'b0;
    end else begin
      edge_pulse <= 1'b0;
      if (load) begin
        level <= sync_p1;
        cnt   <= '0;
      end else if (run) begin
        if (sync_p1 == level) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          level      <= sync_p1;
          cnt        <= '0;
          edge_pulse <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/player_input_conditioner.sv
// ---------------------------------------------------------------------------
// player_input_conditioner
// Synchronises and debounces 5 buttons and 8 switches, provides clean levels
// and edge pulses, and serialises all edges into a small event FIFO.
// Build option: define PIC_BTN_RELEASE_EVT_EN to also queue button releases
// (evt_data[4]=1); otherwise releases produce no event.
// Ports:
//   clk, rst (async, active-low)
//   btns_raw[4:0], sw_raw[7:0]     raw inputs
//   btns_level, sw_level           debounced levels
//   btn_press                      pulse on debounced 0->1 of a button
//   sw_toggle                      pulse on any debounced switch change
//   evt_valid/evt_data/evt_ready   event FIFO head and pop handshake
//   evt_overflow/clr_overflow      sticky drop flag and its clear
// ---------------------------------------------------------------------------
module player_input_conditioner
  import player_input_conditioner_pkg::*;
#(
  parameter int DB_CYCLES  = 500000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] btns_raw,
  input  logic [7:0] sw_raw,
  output logic [4:0] btns_level,
  output logic [7:0] sw_level,
  output logic [4:0] btn_press,
  output logic [7:0] sw_toggle,
  output logic       evt_valid,
  output logic [4:0] evt_data,
  input  logic       evt_ready,
  output logic       evt_overflow,
  input  logic       clr_overflow
);

  localparam int NUM_IN = NUM_BTNS + NUM_SW;
`ifdef PIC_BTN_RELEASE_EVT_EN
  localparam int NUM_EVT = 2 * NUM_BTNS + NUM_SW;
`else
  localparam int NUM_EVT = NUM_BTNS + NUM_SW;
`endif
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  // Control FSM
  logic [1:0] state;
  logic       init_cnt;
  logic       load;
  logic       run;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_INIT;
      init_cnt <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          init_cnt <= 1'b1;
          if (init_cnt) state <= ST_LOAD;
        end
        ST_LOAD: state <= ST_RUN;
        ST_RUN:  state <= ST_RUN;
        default: state <= ST_INIT;
      endcase
    end
  end

  assign load = (state == ST_LOAD);
  assign run  = (state == ST_RUN);

  // Debounce cells: buttons occupy [4:0], switches [12:5]
  logic [NUM_IN-1:0] raw_all;
  logic [NUM_IN-1:0] level_all;
  logic [NUM_IN-1:0] chg_all;

  assign raw_all = {sw_raw, btns_raw};

  for (genvar i = 0; i < NUM_IN; i++) begin : g_cell
    debounce_cell #(.DB_CYCLES(DB_CYCLES)) u_cell (
      .clk        (clk),
      .rst        (rst),
      .raw        (raw_all[i]),
      .load       (load),
      .run        (run),
      .level      (level_all[i]),
      .edge_pulse (chg_all[i])
    );
  end

  assign btns_level = level_all[NUM_BTNS-1:0];
  assign sw_level   = level_all[NUM_IN-1:NUM_BTNS];
  assign btn_press  = chg_all[NUM_BTNS-1:0] & level_all[NUM_BTNS-1:0];
  assign sw_toggle  = chg_all[NUM_IN-1:NUM_BTNS];

  // Pending bits, lowest index has priority
  logic [NUM_EVT-1:0] evt_set;
`ifdef PIC_BTN_RELEASE_EVT_EN
  assign evt_set = {sw_toggle, chg_all[NUM_BTNS-1:0] & ~level_all[NUM_BTNS-1:0], btn_press};
`else
  assign evt_set = {sw_toggle, btn_press};
`endif

  function automatic evt_t evt_code(input int unsigned idx);
    evt_t e;
    if (idx < NUM_BTNS)
      e = make_evt(1'b0, EVT_TYPE_BTN, 3'(idx));
`ifdef PIC_BTN_RELEASE_EVT_EN
    else if (idx < 2 * NUM_BTNS)
      e = make_evt(1'b1, EVT_TYPE_BTN, 3'(idx - NUM_BTNS));
    else
      e = make_evt(1'b0, EVT_TYPE_SW, 3'(idx - 2 * NUM_BTNS));
`else
    else
      e = make_evt(1'b0, EVT_TYPE_SW, 3'(idx - NUM_BTNS));
`endif
    return e;
  endfunction

  logic [NUM_EVT-1:0] pending;
  logic [NUM_EVT-1:0] push_sel;
  logic               push_req;
  evt_t               push_data;

  always_comb begin
    push_req  = 1'b0;
    push_sel  = '0;
    push_data = '0;
    // Descending scan so the lowest set bit is the one left selected
    for (int i = NUM_EVT - 1; i >= 0; i--) begin
      if (pending[i]) begin
        push_req    = 1'b1;
        push_sel    = '0;
        push_sel[i] = 1'b1;
        push_data   = evt_code(i);
      end
    end
  end

  // Event FIFO with an extra pointer bit to tell full from empty
  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;
  evt_t           mem [FIFO_DEPTH];
  logic           fifo_empty;
  logic           fifo_full;
  logic           pop;
  logic           do_push;
  logic           drop;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop        = !fifo_empty && evt_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign do_push    = push_req && (!fifo_full || pop);
  assign drop       = push_req && fifo_full && !pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending      <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      evt_overflow <= 1'b0;
    end else begin
      pending <= (pending & ~push_sel) | evt_set;
      if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      if (drop)              evt_overflow <= 1'b1;
      else if (clr_overflow) evt_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
  end

  assign evt_valid = !fifo_empty;
  assign evt_data  = fifo_empty ? '0 : mem[rd_ptr[PTR_W-1:0]];

endmodule

// File: tb/tb_player_input_conditioner.sv
`timescale 1ns/1ps
module tb_player_input_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] btns_raw;
  logic [7:0] sw_raw;
  logic [4:0] btns_level;
  logic [7:0] sw_level;
  logic [4:0] btn_press;
  logic [7:0] sw_toggle;
  logic       evt_valid;
  logic [4:0] evt_data;
  logic       evt_ready;
  logic       evt_overflow;
  logic       clr_overflow;

  player_input_conditioner #(.DB_CYCLES(4), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .btns_raw     (btns_raw),
    .sw_raw       (sw_raw),
    .btns_level   (btns_level),
    .sw_level     (sw_level),
    .btn_press    (btn_press),
    .sw_toggle    (sw_toggle),
    .evt_valid    (evt_valid),
    .evt_data     (evt_data),
    .evt_ready    (evt_ready),
    .evt_overflow (evt_overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         passes = 0;
  logic [4:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s got=%0h want=%0h", name, got, want);
  endtask

  // Advance to just after the next rising edge (drive and sample point)
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard monitor: compares every popped event with the expected queue
  logic       hold_prev = 1'b0;
  logic [4:0] prev_data = '0;

  always @(negedge clk) begin
    if (rst) begin
      if (evt_valid && hold_prev) check("evt_hold", evt_data, prev_data);
      if (evt_valid && evt_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL evt_unexpected got=%b want=none", evt_data);
        end else begin
          check("evt_data", evt_data, exp_q.pop_front());
        end
      end
      hold_prev <= evt_valid && !evt_ready;
      prev_data <= evt_data;
    end else begin
      hold_prev <= 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic any_tog, any_vld, any_prs;
    int   bounce_press, n_press, pulse_at, first_vld, n_vld;

    rst = 1'b0; btns_raw = '0; sw_raw = 8'hA5; evt_ready = 1'b0; clr_overflow = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_btns_level", btns_level, 5'h00);
    check("rst_sw_level", sw_level, 8'h00);
    check("rst_btn_press", btn_press, 5'h00);
    check("rst_sw_toggle", sw_toggle, 8'h00);
    check("rst_evt_valid", evt_valid, 1'b0);
    check("rst_evt_data", evt_data, 5'h00);
    check("rst_overflow", evt_overflow, 1'b0);

    // Start-up capture: switch position loaded without a toggle or event
    cyc(1);
    rst = 1'b1;
    any_tog = 1'b0; any_vld = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      any_tog |= |sw_toggle;
      any_vld |= evt_valid;
    end
    check("start_sw_level", sw_level, 8'hA5);
    check("start_btns_level", btns_level, 5'h00);
    check("start_toggle", any_tog, 1'b0);
    check("start_valid", any_vld, 1'b0);

    // Bounce on button 2, then a clean rise
    evt_ready = 1'b1;
    bounce_press = 0;
    for (int k = 0; k < 6; k++) begin
      btns_raw[2] = (k % 2 == 0);
      for (int j = 0; j < 2; j++) begin
        cyc(1);
        bounce_press += int'(btn_press[2]);
      end
    end
    check("bounce_no_press", bounce_press, 0);
    exp_q.push_back(5'b00010);
    btns_raw[2] = 1'b1;
    n_press = 0; pulse_at = -1;
    for (int i = 1; i <= 10; i++) begin
      cyc(1);
      if (btn_press[2]) begin
        n_press++;
        pulse_at = i;
      end
    end
    check("press2_count", n_press, 1);
    check("press2_latency", pulse_at, 6);
    check("press2_level", btns_level, 5'b00100);

    // Simultaneous button 0 and switch 3: button first, consecutive pops
    exp_q.push_back(5'b00000);
    exp_q.push_back(5'b01011);
    btns_raw[0] = 1'b1;
    sw_raw = 8'hAD;
    first_vld = -1; n_vld = 0;
    for (int i = 1; i <= 12; i++) begin
      cyc(1);
      if (evt_valid) begin
        n_vld++;
        if (first_vld < 0) first_vld = i;
      end
    end
    check("pair_first_valid", first_vld, 8);
    check("pair_valid_cycles", n_vld, 2);
    check("pair_sw_level", sw_level, 8'hAD);

    // Six edges with no consumer: four queued in priority order, two dropped
    evt_ready = 1'b0;
    exp_q.push_back(5'b00001);
    exp_q.push_back(5'b00011);
    exp_q.push_back(5'b01000);
    exp_q.push_back(5'b01010);
    btns_raw = 5'b01111;
    sw_raw = 8'h08;
    cyc(16);
    check("ovf_set", evt_overflow, 1'b1);
    check("ovf_valid", evt_valid, 1'b1);
    clr_overflow = 1'b1;
    cyc(1);
    clr_overflow = 1'b0;
    check("ovf_cleared", evt_overflow, 1'b0);

    // Full FIFO with a pop in the same cycle as a push: nothing lost
    exp_q.push_back(5'b00100);
    btns_raw = 5'b11111;
    cyc(7);
    evt_ready = 1'b1;
    cyc(10);
    check("full_pp_ovf", evt_overflow, 1'b0);
    check("full_pp_drained", evt_valid, 1'b0);
    check("full_pp_btns", btns_level, 5'h1F);

    // Reset with two events queued
    evt_ready = 1'b0;
    exp_q.push_back(5'b01001);
    exp_q.push_back(5'b01110);
    sw_raw = 8'h4A;
    cyc(12);
    check("pre_rst_valid", evt_valid, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_valid", evt_valid, 1'b0);
    check("mid_rst_data", evt_data, 5'h00);
    check("mid_rst_btns", btns_level, 5'h00);
    check("mid_rst_sw", sw_level, 8'h00);
    exp_q.delete();
    btns_raw = 5'b10010;
    sw_raw = 8'h3C;
    cyc(3);
    rst = 1'b1;
    any_tog = 1'b0; any_vld = 1'b0; any_prs = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      any_tog |= |sw_toggle;
      any_prs |= |btn_press;
      any_vld |= evt_valid;
    end
    check("rerun_btns", btns_level, 5'b10010);
    check("rerun_sw", sw_level, 8'h3C);
    check("rerun_no_toggle", any_tog, 1'b0);
    check("rerun_no_press", any_prs, 1'b0);
    check("rerun_no_valid", any_vld, 1'b0);

    cyc(2);
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
